// File: rtl/mem_ctrl.sv
// Load/store stage controller: translates exe_mem memory requests into data bus
// transactions, extracts and extends load data, and produces the registered
// writeback result for the wb stage. Upstream is held via stall_o while an
// access is in flight. Byte-lane logic assumes a 32-bit data word.
module mem_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned RADDR_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // writeback fields from exe_mem
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
   // memory request from exe_mem
   input  logic                   mem_we_i,
   input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   input  logic [3:0]             mem_op_i,
   // registered writeback result
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o,
   output logic                   stall_o,
   output logic                   misalign_o,
   // data bus
   output logic                   dbus_req_o,
   output logic                   dbus_we_o,
   output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
   output logic [3:0]             dbus_be_o,
   output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
   input  logic                   dbus_gnt_i,
   input  logic                   dbus_rvalid_i,
   input  logic [DATA_WIDTH-1:0]  dbus_rdata_i
);

   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLh  = 4'd2;
   localparam logic [3:0] OpLw  = 4'd3;
   localparam logic [3:0] OpLbu = 4'd4;
   localparam logic [3:0] OpLhu = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   state_e state_q, state_d;

   // Captured request
   logic [3:0]             op_q;
   logic                   store_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [1:0]             off_q;
   logic [3:0]             be_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [RADDR_WIDTH-1:0] rd_waddr_q;
   logic                   rd_we_q;
   logic [DATA_WIDTH-1:0]  rd_wdata_q;
   logic [DATA_WIDTH-1:0]  load_q;

   // Registered outputs
   logic [RADDR_WIDTH-1:0] reg_waddr_q;
   logic                   reg_we_q;
   logic [DATA_WIDTH-1:0]  reg_wdata_q;
   logic                   misalign_q;

   // Decode of the incoming request
   logic                   is_load;
   logic                   is_store;
   logic                   misaligned;
   logic [3:0]             req_be;
   logic [DATA_WIDTH-1:0]  req_wdata;
   logic                   start;
   logic                   stall;

   // Load extraction
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;
   logic [DATA_WIDTH-1:0]  load_ext;

   // The op code alone decides direction; mem_we_i is redundant.
   logic unused_mem_we;
   assign unused_mem_we = mem_we_i;

   // Decode op into direction, alignment check, byte enables and lane-replicated data
   always_comb begin
      is_load    = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      req_be     = 4'b1111;
      req_wdata  = mem_data_i;
      case (mem_op_i)
         OpLb, OpLbu: is_load = 1'b1;
         OpLh, OpLhu: begin
            is_load    = 1'b1;
            misaligned = mem_addr_i[0];
         end
         OpLw: begin
            is_load    = 1'b1;
            misaligned = |mem_addr_i[1:0];
         end
         OpSb: begin
            is_store  = 1'b1;
            req_be    = 4'b0001 << mem_addr_i[1:0];
            req_wdata = {4{mem_data_i[7:0]}};
         end
         OpSh: begin
            is_store   = 1'b1;
            misaligned = mem_addr_i[0];
            req_be     = 4'b0011 << mem_addr_i[1:0];
            req_wdata  = {2{mem_data_i[15:0]}};
         end
         OpSw: begin
            is_store   = 1'b1;
            misaligned = |mem_addr_i[1:0];
         end
         default: ;
      endcase
   end

   assign start = (state_q == StIdle) && (is_load || is_store) && !misaligned;

   // Next-state logic and internal stall request
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               stall   = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            stall = 1'b1;
            if (dbus_gnt_i) begin
               state_d = store_q ? StDone : StResp;
            end
         end
         StResp: begin
            stall = 1'b1;
            if (dbus_rvalid_i) begin
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Upstream must not see a stall while reset is held
   assign stall_o = rst_i & stall;

   // Pick the addressed byte/halfword of the returned word and extend it
   always_comb begin
      byte_sel = dbus_rdata_i[{off_q, 3'b000} +: 8];
      half_sel = dbus_rdata_i[{off_q[1], 4'b0000} +: 16];
      load_ext = dbus_rdata_i;
      case (op_q)
         OpLb:    load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         OpLbu:   load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         OpLh:    load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         OpLhu:   load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request on acceptance and the extended load data on rvalid
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         op_q       <= '0;
         store_q    <= 1'b0;
         addr_q     <= '0;
         off_q      <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rd_waddr_q <= '0;
         rd_we_q    <= 1'b0;
         rd_wdata_q <= '0;
         load_q     <= '0;
      end else begin
         if (start) begin
            op_q       <= mem_op_i;
            store_q    <= is_store;
            addr_q     <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            off_q      <= mem_addr_i[1:0];
            be_q       <= req_be;
            wdata_q    <= req_wdata;
            rd_waddr_q <= reg_waddr_i;
            rd_we_q    <= reg_we_i;
            rd_wdata_q <= reg_wdata_i;
         end
         if ((state_q == StResp) && dbus_rvalid_i) begin
            load_q <= load_ext;
         end
      end
   end

   // Writeback result: bubble while stalled, pass-through in IDLE, access result in DONE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         reg_waddr_q <= '0;
         reg_we_q    <= 1'b0;
         reg_wdata_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         misalign_q <= (state_q == StIdle) && (is_load || is_store) && misaligned;
         if (stall) begin
            reg_we_q <= 1'b0;
         end else if (state_q == StDone) begin
            reg_waddr_q <= rd_waddr_q;
            reg_we_q    <= rd_we_q;
            reg_wdata_q <= store_q ? rd_wdata_q : load_q;
         end else if (state_q == StIdle) begin
            reg_waddr_q <= reg_waddr_i;
            reg_we_q    <= reg_we_i && !((is_load || is_store) && misaligned);
            reg_wdata_q <= reg_wdata_i;
         end
      end
   end

   assign reg_waddr_o = reg_waddr_q;
   assign reg_we_o    = reg_we_q;
   assign reg_wdata_o = reg_wdata_q;
   assign misalign_o  = misalign_q;

   // Bus fields are only driven while the request is outstanding
   assign dbus_req_o   = (state_q == StReq);
   assign dbus_we_o    = dbus_req_o & store_q;
   assign dbus_addr_o  = dbus_req_o ? addr_q : '0;
   assign dbus_be_o    = dbus_req_o ? be_q : '0;
   assign dbus_wdata_o = dbus_req_o ? wdata_q : '0;

endmodule
